// File: rtl/axis_input_packer.sv
// axis_input_packer
//   Packs a narrow AXI-Stream from the DMA engine into the wide beats that
//   the systolic array's slave port consumes. Lane order is little-endian.
//   A beat completes when the last lane fills or when TLAST arrives. Lanes
//   that were never filled go out as data 0 with keep 0.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   S_AXIS_*          narrow input stream (TDATA/TKEEP/TLAST/TVALID/TREADY)
//   M_AXIS_*          wide output stream  (TDATA/TKEEP/TLAST/TVALID/TREADY)
//   keepError         sticky flag: a non-last word arrived with partial TKEEP

// One accumulator lane. It holds a single narrow word until the beat
// completes, and it selects what this lane contributes to the outgoing beat.
module packerLane #(
  parameter int inBits   = 32,
  parameter int keepBits = inBits / 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wrEn,     // store the incoming word in this lane
  input  logic                clrEn,    // beat completed, empty the lane
  input  logic [inBits-1:0]   inData,
  input  logic [keepBits-1:0] inKeep,
  input  logic                selIn,    // this lane is the one being written now
  input  logic                selAcc,   // this lane was filled earlier in the beat
  output logic [inBits-1:0]   laneData,
  output logic [keepBits-1:0] laneKeep
);

  logic [inBits-1:0]   accData;
  logic [keepBits-1:0] accKeep;

  always_ff @(posedge clk) begin
    if (rst || clrEn) begin
      accData <= '0;
      accKeep <= '0;
    end else if (wrEn) begin
      accData <= inData;
      accKeep <= inKeep;
    end
  end

  // Lanes that are neither current nor already filled are forced to zero,
  // so a short beat never leaks stale contents.
  always_comb begin
    laneData = '0;
    laneKeep = '0;
    if (selIn) begin
      laneData = inData;
      laneKeep = inKeep;
    end else if (selAcc) begin
      laneData = accData;
      laneKeep = accKeep;
    end
  end

endmodule

module axis_input_packer #(
  parameter int arraySize = 2,
  parameter int inputBits = 8,
  parameter int inBits    = 32,
  parameter int outBits   = arraySize * inputBits * 3 + 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [inBits-1:0]    S_AXIS_TDATA,
  input  logic [inBits/8-1:0]  S_AXIS_TKEEP,
  input  logic                 S_AXIS_TLAST,
  input  logic                 S_AXIS_TVALID,
  output logic                 S_AXIS_TREADY,
  output logic [outBits-1:0]   M_AXIS_TDATA,
  output logic [outBits/8-1:0] M_AXIS_TKEEP,
  output logic                 M_AXIS_TLAST,
  output logic                 M_AXIS_TVALID,
  input  logic                 M_AXIS_TREADY,
  output logic                 keepError
);

  localparam int WORDS    = outBits / inBits;
  localparam int cntWidth = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int keepBits = inBits / 8;
  localparam logic [cntWidth-1:0] lastLane = cntWidth'(WORDS - 1);

  logic [cntWidth-1:0] cnt;
  logic                accept;
  logic                complete;

  logic [WORDS-1:0][inBits-1:0]   mergedData;
  logic [WORDS-1:0][keepBits-1:0] mergedKeep;

  logic [outBits-1:0]   mData;
  logic [outBits/8-1:0] mKeep;
  logic                 mLast;
  logic                 mValid;
  logic                 errFlag;

  // Ready follows the output register: space exists if it is empty or is
  // draining this cycle, so back-to-back beats flow without a bubble.
  assign S_AXIS_TREADY = !mValid || M_AXIS_TREADY;
  assign accept        = S_AXIS_TVALID && S_AXIS_TREADY;
  assign complete      = accept && ((cnt == lastLane) || S_AXIS_TLAST);

  genvar k;
  generate
    for (k = 0; k < WORDS; k++) begin : gLane
      logic selIn;
      logic selAcc;
      assign selIn  = (cnt == cntWidth'(k));
      assign selAcc = (cnt >  cntWidth'(k));

      packerLane #(.inBits(inBits), .keepBits(keepBits)) uLane (
        .clk     (clk),
        .rst     (rst),
        .wrEn    (accept && !complete && selIn),
        .clrEn   (complete),
        .inData  (S_AXIS_TDATA),
        .inKeep  (S_AXIS_TKEEP),
        .selIn   (selIn),
        .selAcc  (selAcc),
        .laneData(mergedData[k]),
        .laneKeep(mergedKeep[k])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (complete) begin
      cnt <= '0;
    end else if (accept) begin
      cnt <= cnt + cntWidth'(1);
    end
  end

  // Output register: a new beat may load in the same cycle the old one
  // drains; otherwise contents hold while the array stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      mData  <= '0;
      mKeep  <= '0;
      mLast  <= 1'b0;
      mValid <= 1'b0;
    end else if (complete) begin
      mData  <= mergedData;
      mKeep  <= mergedKeep;
      mLast  <= S_AXIS_TLAST;
      mValid <= 1'b1;
    end else if (mValid && M_AXIS_TREADY) begin
      mValid <= 1'b0;
    end
  end

  // Only a final word may be partially kept; anything else is flagged but
  // still packed as received.
  always_ff @(posedge clk) begin
    if (rst) begin
      errFlag <= 1'b0;
    end else if (accept && !S_AXIS_TLAST && (S_AXIS_TKEEP != {keepBits{1'b1}})) begin
      errFlag <= 1'b1;
    end
  end

  assign M_AXIS_TDATA  = mData;
  assign M_AXIS_TKEEP  = mKeep;
  assign M_AXIS_TLAST  = mLast;
  assign M_AXIS_TVALID = mValid;
  assign keepError     = errFlag;

endmodule

// File: tb/tb_axis_input_packer.sv
module tb_axis_input_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] sData;
  logic [3:0]  sKeep;
  logic        sLast;
  logic        sValid;
  logic        sReady;
  logic [63:0] mData;
  logic [7:0]  mKeep;
  logic        mLast;
  logic        mValid;
  logic        mReady;
  logic        keepError;

  int total = 0;
  int bad   = 0;

  logic [63:0] beatData[$];
  logic        beatLast[$];

  always #5 clk = ~clk;

  axis_input_packer #(.arraySize(2), .inputBits(8), .inBits(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .S_AXIS_TDATA (sData),
    .S_AXIS_TKEEP (sKeep),
    .S_AXIS_TLAST (sLast),
    .S_AXIS_TVALID(sValid),
    .S_AXIS_TREADY(sReady),
    .M_AXIS_TDATA (mData),
    .M_AXIS_TKEEP (mKeep),
    .M_AXIS_TLAST (mLast),
    .M_AXIS_TVALID(mValid),
    .M_AXIS_TREADY(mReady),
    .keepError    (keepError)
  );

  // Record every beat the array actually takes.
  always @(posedge clk) begin
    if (!rst && mValid && mReady) begin
      beatData.push_back(mData);
      beatLast.push_back(mLast);
    end
  end

  // Present one word and return #1 after the edge that accepted it.
  task automatic send(input logic [31:0] d, input logic [3:0] kp, input logic l);
    logic r;
    int   n;
    sData = d; sKeep = kp; sLast = l; sValid = 1'b1;
    n = 0;
    r = 1'b0;
    while (!r && n < 50) begin
      @(negedge clk);
      r = sReady;
      @(posedge clk);
      #1;
      n++;
    end
    sValid = 1'b0;
    if (!r) begin
      total++; bad++;
      $display("FAIL send_timeout word=%h never accepted", d);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; sValid = 1'b0; sData = '0; sKeep = '0; sLast = 1'b0; mReady = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    total++; if (mValid !== 1'b0)    begin bad++; $display("FAIL reset_valid got=%b want=0", mValid); end
    total++; if (mData !== 64'h0)    begin bad++; $display("FAIL reset_data got=%h want=0", mData); end
    total++; if (mKeep !== 8'h0)     begin bad++; $display("FAIL reset_keep got=%h want=0", mKeep); end
    total++; if (keepError !== 1'b0) begin bad++; $display("FAIL reset_keeperr got=%b want=0", keepError); end
    total++; if (sReady !== 1'b1)    begin bad++; $display("FAIL reset_ready got=%b want=1", sReady); end
  endtask

  task automatic test_full_beat();
    send(32'h11111111, 4'hF, 1'b0);
    total++; if (mValid !== 1'b0) begin bad++; $display("FAIL full_early_valid got=%b want=0", mValid); end
    send(32'h22222222, 4'hF, 1'b1);
    total++; if (mData !== 64'h22222222_11111111) begin bad++; $display("FAIL full_data got=%h want=2222222211111111", mData); end
    total++; if (mKeep !== 8'hFF) begin bad++; $display("FAIL full_keep got=%h want=ff", mKeep); end
    total++; if (mLast !== 1'b1)  begin bad++; $display("FAIL full_last got=%b want=1", mLast); end
    total++; if (mValid !== 1'b1) begin bad++; $display("FAIL full_valid got=%b want=1", mValid); end
    @(posedge clk); #1;
    total++; if (mValid !== 1'b0) begin bad++; $display("FAIL full_valid_drop got=%b want=0", mValid); end
  endtask

  task automatic test_short_packet();
    send(32'hAABBCCDD, 4'hF, 1'b1);
    total++; if (mData !== 64'h00000000_AABBCCDD) begin bad++; $display("FAIL short_data got=%h want=00000000aabbccdd", mData); end
    total++; if (mKeep !== 8'h0F) begin bad++; $display("FAIL short_keep got=%h want=0f", mKeep); end
    total++; if (mLast !== 1'b1)  begin bad++; $display("FAIL short_last got=%b want=1", mLast); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    beatData.delete();
    beatLast.delete();
    mReady = 1'b0;
    send(32'h1, 4'hF, 1'b0);
    send(32'h2, 4'hF, 1'b0);
    sData = 32'h3; sKeep = 4'hF; sLast = 1'b0; sValid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      total++; if (mData !== 64'h00000002_00000001) begin bad++; $display("FAIL stall_hold_data cyc=%0d got=%h want=0000000200000001", i, mData); end
      total++; if (sReady !== 1'b0 || mValid !== 1'b1) begin bad++; $display("FAIL stall_ready cyc=%0d ready=%b valid=%b want 0/1", i, sReady, mValid); end
      @(posedge clk); #1;
    end
    mReady = 1'b1;
    @(posedge clk); #1;
    send(32'h4, 4'hF, 1'b1);
    @(posedge clk); #1;
    total++; if (beatData.size() !== 2) begin bad++; $display("FAIL b2b_count got=%0d want=2", beatData.size()); end
    if (beatData.size() == 2) begin
      total++; if (beatData[0] !== 64'h00000002_00000001 || beatLast[0] !== 1'b0) begin bad++; $display("FAIL b2b_beat0 got=%h/%b want=0000000200000001/0", beatData[0], beatLast[0]); end
      total++; if (beatData[1] !== 64'h00000004_00000003 || beatLast[1] !== 1'b1) begin bad++; $display("FAIL b2b_beat1 got=%h/%b want=0000000400000003/1", beatData[1], beatLast[1]); end
    end
  endtask

  task automatic test_partial_last();
    send(32'h12345678, 4'hF, 1'b0);
    send(32'h0000BEEF, 4'h3, 1'b1);
    total++; if (mData !== 64'h0000BEEF_12345678) begin bad++; $display("FAIL plast_data got=%h want=0000beef12345678", mData); end
    total++; if (mKeep !== 8'h3F) begin bad++; $display("FAIL plast_keep got=%h want=3f", mKeep); end
    total++; if (keepError !== 1'b0) begin bad++; $display("FAIL plast_keeperr got=%b want=0", keepError); end
    @(posedge clk); #1;
  endtask

  task automatic test_keep_error();
    send(32'h0000CAFE, 4'h7, 1'b0);
    total++; if (keepError !== 1'b1) begin bad++; $display("FAIL kerr_set got=%b want=1", keepError); end
    send(32'h00000005, 4'hF, 1'b1);
    total++; if (mData !== 64'h00000005_0000CAFE || mKeep !== 8'hF7) begin bad++; $display("FAIL kerr_beat got=%h/%h want=000000050000cafe/f7", mData, mKeep); end
    send(32'h00000006, 4'hF, 1'b0);
    send(32'h00000007, 4'hF, 1'b1);
    @(posedge clk); #1;
    total++; if (keepError !== 1'b1) begin bad++; $display("FAIL kerr_sticky got=%b want=1", keepError); end
  endtask

  task automatic test_mid_reset();
    send(32'hDEAD0000, 4'hF, 1'b0);
    sData = 32'h99; sKeep = 4'hF; sLast = 1'b1; sValid = 1'b1;
    rst = 1'b1;
    @(posedge clk); #1;
    total++; if (mValid !== 1'b0 || keepError !== 1'b0) begin bad++; $display("FAIL mrst_during valid=%b kerr=%b want 0/0", mValid, keepError); end
    rst = 1'b0; sValid = 1'b0;
    @(posedge clk); #1;
    total++; if (mValid !== 1'b0 || sReady !== 1'b1) begin bad++; $display("FAIL mrst_after valid=%b ready=%b want 0/1", mValid, sReady); end
    send(32'h1, 4'hF, 1'b0);
    send(32'h2, 4'hF, 1'b1);
    total++; if (mData !== 64'h00000002_00000001 || mKeep !== 8'hFF || mLast !== 1'b1) begin bad++; $display("FAIL mrst_beat got=%h/%h/%b want=0000000200000001/ff/1", mData, mKeep, mLast); end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_full_beat();
    test_short_packet();
    test_back_to_back();
    test_partial_last();
    test_keep_error();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
